// File: rtl/uart_alu_engine.sv
// uart_alu_engine: byte-framed MIPS R-type ALU behind a UART rx/tx byte interface.
// A frame is funct, then NB bytes of A, then NB bytes of B (both LSB first).
// The reply is a status byte, followed by NB result bytes LSB first for good functs.
module uart_alu_engine #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 50000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] led,
    output logic       busy,
    output logic       err_funct,
    output logic       err_timeout,
    output logic       overrun
);

    localparam int          NB        = WIDTH / 8;
    localparam int          SHW       = $clog2(WIDTH);
    localparam logic [2:0]  LAST_BYTE = 3'(NB - 1);
    localparam logic [31:0] TMO_LAST  = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_A    = 3'd1,
        RX_B    = 3'd2,
        EXEC    = 3'd3,
        TX_STAT = 3'd4,
        TX_RES  = 3'd5
    } state_t;

    state_t             state;
    logic [7:0]         funct;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   tx_shift;
    logic               frame_bad;
    logic [2:0]         byte_cnt;
    logic [31:0]        tmo_cnt;
    logic               tmo_fire;
    logic [WIDTH:0]     alu_out;

    // Shift a new byte in at the top so the first (least significant) byte ends at bit 0.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic [7:0] b);
        logic [WIDTH+7:0] tmp;
        tmp = {b, cur};
        return tmp[WIDTH+7:8];
    endfunction

    // Returns {supported, result}; unsupported functs yield a zero result.
    function automatic logic [WIDTH:0] alu_exec(input logic [7:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic [SHW-1:0]          sh;
        logic [WIDTH-1:0]        r;
        logic                    ok;
        xs = x;
        ys = y;
        sh = y[SHW-1:0];
        r  = '0;
        ok = 1'b1;
        case (f)
            8'd32:   r = x + y;
            8'd34:   r = x - y;
            8'd36:   r = x & y;
            8'd37:   r = x | y;
            8'd38:   r = x ^ y;
            8'd39:   r = ~(x | y);
            8'd42:   r = {{(WIDTH-1){1'b0}}, (xs < ys)};
            8'd43:   r = {{(WIDTH-1){1'b0}}, (x < y)};
            8'd0:    r = x << sh;
            8'd2:    r = x >> sh;
            8'd3:    r = xs >>> sh;
            default: begin
                r  = '0;
                ok = 1'b0;
            end
        endcase
        return {ok, r};
    endfunction

    assign alu_out  = alu_exec(funct, op_a, op_b);
    assign tmo_fire = (TIMEOUT > 0) && (tmo_cnt == TMO_LAST);
    assign busy     = (state != IDLE);

    // Frame FSM: receive, execute, transmit; all outputs registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            funct       <= '0;
            op_a        <= '0;
            op_b        <= '0;
            tx_shift    <= '0;
            frame_bad   <= 1'b0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            led         <= '0;
            err_funct   <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        funct    <= rx_data;
                        byte_cnt <= '0;
                        tmo_cnt  <= '0;
                        state    <= RX_A;
                    end
                end
                RX_A: begin
                    if (tmo_fire) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else if (rx_valid) begin
                        op_a    <= shift_in(op_a, rx_data);
                        tmo_cnt <= '0;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            state    <= RX_B;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                RX_B: begin
                    if (tmo_fire) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else if (rx_valid) begin
                        op_b    <= shift_in(op_b, rx_data);
                        tmo_cnt <= '0;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            state    <= EXEC;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                EXEC: begin
                    if (rx_valid) overrun <= 1'b1;
                    tx_shift    <= alu_out[WIDTH-1:0];
                    frame_bad   <= ~alu_out[WIDTH];
                    err_funct   <= ~alu_out[WIDTH];
                    err_timeout <= 1'b0;
                    if (alu_out[WIDTH]) led <= alu_out[7:0];
                    tx_data     <= alu_out[WIDTH] ? 8'h00 : 8'hFF;
                    tx_valid    <= 1'b1;
                    state       <= TX_STAT;
                end
                TX_STAT: begin
                    if (rx_valid) overrun <= 1'b1;
                    if (tx_ready) begin
                        if (frame_bad) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_data  <= tx_shift[7:0];
                            tx_shift <= tx_shift >> 8;
                            byte_cnt <= '0;
                            state    <= TX_RES;
                        end
                    end
                end
                TX_RES: begin
                    if (rx_valid) overrun <= 1'b1;
                    if (tx_ready) begin
                        if (byte_cnt == LAST_BYTE) begin
                            tx_valid <= 1'b0;
                            byte_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            tx_data  <= tx_shift[7:0];
                            tx_shift <= tx_shift >> 8;
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_engine.sv
// Directed testbench for uart_alu_engine: an 8-bit and a 16-bit instance share clock and reset.
module tb_uart_alu_engine;

    logic clk;
    logic reset_n;

    logic [7:0] rx_data8, tx_data8, led8;
    logic       rx_valid8, tx_valid8, tx_ready8, busy8, errf8, errt8, ovr8;
    logic [7:0] rx_data16, tx_data16, led16;
    logic       rx_valid16, tx_valid16, tx_ready16, busy16, errf16, errt16, ovr16;

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [7:0] cap8 [0:255];
    logic [7:0] cap16[0:255];
    int         n8  = 0;
    int         n16 = 0;

    uart_alu_engine #(.WIDTH(8), .TIMEOUT(100)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data8), .rx_valid(rx_valid8),
        .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
        .led(led8), .busy(busy8), .err_funct(errf8), .err_timeout(errt8), .overrun(ovr8)
    );

    uart_alu_engine #(.WIDTH(16), .TIMEOUT(100)) dut16 (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data16), .rx_valid(rx_valid16),
        .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
        .led(led16), .busy(busy16), .err_funct(errf16), .err_timeout(errt16), .overrun(ovr16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every byte that will be handed over at the next rising edge.
    always @(negedge clk) begin
        if (tx_valid8 && tx_ready8) begin
            cap8[n8[7:0]] = tx_data8;
            n8 = n8 + 1;
        end
        if (tx_valid16 && tx_ready16) begin
            cap16[n16[7:0]] = tx_data16;
            n16 = n16 + 1;
        end
    end

    typedef struct {
        logic [7:0]  funct;
        logic [15:0] a;
        logic [15:0] b;
        logic        good;
        logic [15:0] res;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send8(input logic [7:0] b);
        rx_data8  = b;
        rx_valid8 = 1'b1;
        tick();
        rx_valid8 = 1'b0;
    endtask

    task automatic send16(input logic [7:0] b);
        rx_data16  = b;
        rx_valid16 = 1'b1;
        tick();
        rx_valid16 = 1'b0;
    endtask

    task automatic frame16(input logic [7:0] f, input logic [15:0] a, input logic [15:0] b);
        send16(f);
        send16(a[7:0]);
        send16(a[15:8]);
        send16(b[7:0]);
        send16(b[15:8]);
    endtask

    task automatic wait_idle16();
        int k;
        k = 0;
        while (busy16 && k < 60) begin
            tick();
            k++;
        end
        chk("idle16_within_budget", {31'd0, busy16}, 32'd0);
    endtask

    // Check one 16-bit frame reply captured from index base.
    task automatic chk_reply16(input string name, input int base, input logic good,
                               input logic [15:0] res);
        chk({name, "_nbytes"}, 32'(n16 - base), good ? 32'd3 : 32'd1);
        chk({name, "_status"}, {24'd0, cap16[8'(base)]}, good ? 32'h00 : 32'hFF);
        if (good) begin
            chk({name, "_res_lo"}, {24'd0, cap16[8'(base + 1)]}, {24'd0, res[7:0]});
            chk({name, "_res_hi"}, {24'd0, cap16[8'(base + 2)]}, {24'd0, res[15:8]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        logic [7:0] led_exp;
        logic       stable;

        vecs[0]  = '{8'd32, 16'h1234, 16'h1111, 1'b1, 16'h2345};
        vecs[1]  = '{8'd34, 16'h0001, 16'h0002, 1'b1, 16'hFFFF};
        vecs[2]  = '{8'd36, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030};
        vecs[3]  = '{8'd37, 16'hF000, 16'h000F, 1'b1, 16'hF00F};
        vecs[4]  = '{8'd38, 16'hFFFF, 16'h1234, 1'b1, 16'hEDCB};
        vecs[5]  = '{8'd39, 16'h0F0F, 16'h00FF, 1'b1, 16'hF000};
        vecs[6]  = '{8'd3,  16'h8000, 16'h0013, 1'b1, 16'hF000};
        vecs[7]  = '{8'd42, 16'hFFFF, 16'h0001, 1'b1, 16'h0001};
        vecs[8]  = '{8'd43, 16'hFFFF, 16'h0001, 1'b1, 16'h0000};
        vecs[9]  = '{8'd0,  16'h0001, 16'h0024, 1'b1, 16'h0010};
        vecs[10] = '{8'd17, 16'h1234, 16'h5678, 1'b0, 16'h0000};
        vecs[11] = '{8'd2,  16'h8000, 16'hFFF3, 1'b1, 16'h1000};

        reset_n    = 1'b0;
        rx_data8   = 8'h00; rx_valid8  = 1'b0; tx_ready8  = 1'b1;
        rx_data16  = 8'h00; rx_valid16 = 1'b0; tx_ready16 = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        chk("rst_tx_valid", {31'd0, tx_valid16}, 32'd0);
        chk("rst_tx_data",  {24'd0, tx_data16}, 32'd0);
        chk("rst_led",      {24'd0, led16}, 32'd0);
        chk("rst_busy",     {31'd0, busy16}, 32'd0);
        chk("rst_flags",    {29'd0, errf16, errt16, ovr16}, 32'd0);
        chk("rst8_outputs", {14'd0, tx_valid8, busy8, errf8, errt8, ovr8, led8, tx_data8}, 32'd0);

        // 8-bit add with exact reply timing.
        base = n8;
        send8(8'h20);
        send8(8'h05);
        send8(8'h03);
        tick();
        chk("w8_status_valid", {31'd0, tx_valid8}, 32'd1);
        chk("w8_status_data",  {24'd0, tx_data8}, 32'h00);
        tick();
        chk("w8_busy_before_last", {31'd0, busy8}, 32'd1);
        tick();
        chk("w8_busy_after_last", {31'd0, busy8}, 32'd0);
        chk("w8_nbytes", 32'(n8 - base), 32'd2);
        chk("w8_result", {24'd0, cap8[8'(base + 1)]}, 32'h08);
        chk("w8_led", {24'd0, led8}, 32'h08);

        // 16-bit table of operations.
        led_exp = 8'h00;
        for (int i = 0; i < 12; i++) begin
            base = n16;
            frame16(vecs[i].funct, vecs[i].a, vecs[i].b);
            wait_idle16();
            chk_reply16($sformatf("vec%0d", i), base, vecs[i].good, vecs[i].res);
            if (vecs[i].good) led_exp = vecs[i].res[7:0];
            chk($sformatf("vec%0d_led", i), {24'd0, led16}, {24'd0, led_exp});
            chk($sformatf("vec%0d_err_funct", i), {31'd0, errf16}, {31'd0, ~vecs[i].good});
        end
        chk("ovr_clear_after_table", {31'd0, ovr16}, 32'd0);

        // Timeout: funct plus one A byte, then silence.
        base = n16;
        send16(8'h20);
        send16(8'h05);
        for (int i = 0; i < 90; i++) tick();
        chk("tmo_still_busy", {31'd0, busy16}, 32'd1);
        for (int i = 0; i < 12; i++) tick();
        chk("tmo_idle", {31'd0, busy16}, 32'd0);
        chk("tmo_err", {31'd0, errt16}, 32'd1);
        chk("tmo_no_tx", 32'(n16 - base), 32'd0);
        base = n16;
        frame16(8'd32, 16'h0001, 16'h0001);
        wait_idle16();
        chk_reply16("after_tmo", base, 1'b1, 16'h0002);
        chk("tmo_err_cleared", {31'd0, errt16}, 32'd0);

        // Backpressure during the result bytes, plus an rx byte while transmitting.
        base = n16;
        tx_ready16 = 1'b0;
        frame16(8'd32, 16'h1234, 16'h1111);
        tick();
        chk("bp_status_valid", {31'd0, tx_valid16}, 32'd1);
        chk("bp_status_data", {24'd0, tx_data16}, 32'h00);
        tx_ready16 = 1'b1;
        tick();
        tx_ready16 = 1'b0;
        chk("bp_res0_data", {24'd0, tx_data16}, 32'h45);
        send16(8'h55);
        stable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (!(tx_valid16 && tx_data16 == 8'h45)) stable = 1'b0;
            tick();
        end
        chk("bp_stable", {31'd0, stable}, 32'd1);
        chk("bp_overrun", {31'd0, ovr16}, 32'd1);
        tx_ready16 = 1'b1;
        wait_idle16();
        chk_reply16("bp", base, 1'b1, 16'h2345);
        chk("bp_overrun_sticky", {31'd0, ovr16}, 32'd1);

        // Reset in the middle of RX_B.
        send16(8'h20);
        send16(8'h01);
        send16(8'h00);
        send16(8'h02);
        chk("mid_rxb_busy", {31'd0, busy16}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy16}, 32'd0);
        chk("mid_rst_tx", {23'd0, tx_valid16, tx_data16}, 32'd0);
        chk("mid_rst_led", {24'd0, led16}, 32'd0);
        chk("mid_rst_flags", {29'd0, errf16, errt16, ovr16}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        base = n16;
        frame16(8'd32, 16'h0003, 16'h0004);
        wait_idle16();
        chk_reply16("post_rst", base, 1'b1, 16'h0007);
        chk("post_rst_led", {24'd0, led16}, 32'h07);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_alu_engine.md
Name: uart_alu_engine

Overview:
- Parametrised successor to the board-level UART ALU.
- Accepts a framed command from the UART receiver as a byte stream: a funct byte, then operand A, then operand B.
- Executes the MIPS R-type funct operation at WIDTH bits, then returns a status byte and the result over the UART transmitter with a valid/ready handshake.
- Mirrors the low result byte and error flags on the board LEDs.

Parameters:
- WIDTH, 8, operand/result width in bits; multiple of 8, range 8..32; NB = WIDTH/8 bytes per operand.
- TIMEOUT, 50000000, max clk cycles between bytes of one frame before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from UART receiver
- rx_valid  in  1  one-cycle strobe: rx_data valid this cycle
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  transmitter can accept a byte this cycle
- led  out  8  low 8 bits of last good result
- busy  out  1  high in any state other than IDLE
- err_funct  out  1  last frame had an unsupported funct
- err_timeout  out  1  a frame was aborted by timeout
- overrun  out  1  sticky: an rx byte arrived during EXEC/TX and was dropped

Behaviour:
- Reset values: tx_valid=0, tx_data=0, led=0, busy=0, err_funct=0, err_timeout=0, overrun=0, state=IDLE, operands and counters=0.
- Reset is effective in any state, including mid-frame or mid-transmit. A partial frame is discarded and tx_valid drops immediately.
- States: IDLE, RX_A, RX_B, EXEC, TX_STAT, TX_RES.
- IDLE: on rx_valid, latch funct=rx_data, go to RX_A.
- RX_A: collect NB bytes on rx_valid, LSB first, into A; after the NB-th byte go to RX_B.
- RX_B: collect NB bytes into B the same way; after the NB-th byte go to EXEC.
- EXEC: exactly one cycle. Compute and register the result, then go to TX_STAT.
- Supported functs, all results mod 2^WIDTH:
  - 32 add: A+B
  - 34 sub: A-B
  - 36 and
  - 37 or
  - 38 xor
  - 39 nor
  - 42 slt: signed A<B gives 1, else 0, zero-extended
  - 43 sltu: unsigned compare, same encoding
  - 0 sll: A << sh
  - 2 srl: A >> sh, logical
  - 3 sra: A >> sh, arithmetic (sign-filled)
- Shift amount sh = B[clog2(WIDTH)-1:0]; upper bits of B are ignored.
- Unsupported funct: result=0, status=0xFF, err_funct=1. Otherwise status=0x00 and err_funct=0.
- led updates with result[7:0] in EXEC only for good functs.
- TX_STAT: tx_valid=1, tx_data=status.
  - Transfer occurs on a rising edge where tx_valid&&tx_ready; tx_data stays stable until then.
  - After transfer: good funct goes to TX_RES; bad funct goes to IDLE. An error frame sends the status byte only.
- TX_RES: send NB result bytes LSB first, one per accepted handshake. tx_valid may stay high between bytes. After the last transfer, tx_valid=0 and go to IDLE.
- Throughput: with tx_ready held high, the first status byte is valid the cycle after EXEC, and bytes leave back-to-back.
- Timeout (TIMEOUT>0):
  - Counter clears on every accepted byte and on entry to RX_A.
  - Counter increments each cycle in RX_A/RX_B.
  - When it reaches TIMEOUT: go to IDLE, set err_timeout=1, send nothing.
  - err_timeout clears when the next frame completes EXEC.
- rx_valid in EXEC/TX_STAT/TX_RES: byte dropped, overrun=1 (sticky until reset).
- rx_valid in the same cycle the timeout fires: the timeout wins and the byte is dropped. overrun is not set.
- busy=0 only in IDLE.

Test Plan:
1. WIDTH=8, tx_ready=1; send 0x20,0x05,0x03 -> tx bytes 0x00,0x08; led=0x08; busy low one cycle after the final handshake.
2. WIDTH=16; send 0x22, A=0x0001 (01,00), B=0x0002 (02,00) -> tx 0x00,0xFF,0xFF (sub wraps to 0xFFFF); led=0xFF.
3. WIDTH=16; sra, A=0x8000, B=0x0013 (sh=3) -> tx 0x00,0x00,0xF0. Then slt A=0xFFFF, B=0x0001 -> result 0x0001; sltu with the same operands -> 0x0000.
4. Send funct 0x11 plus operands -> single tx byte 0xFF, err_funct=1, led unchanged. A following good add clears err_funct.
5. TIMEOUT=100; send funct and one A byte, then idle 100 cycles -> return to IDLE, err_timeout=1, no tx. A new full frame completes normally.
6. Backpressure/reset: hold tx_ready=0 for 10 cycles during TX_RES -> tx_data stable, no byte lost. An rx byte during TX sets overrun. Asserting reset_n=0 mid-RX_B -> all outputs go to their reset values immediately.
